// File: rtl/amp_fault_supervisor.sv
// amp_fault_supervisor
// Power-up, configuration and fault-recovery sequencer for the external class-D amp.
// Brings the amp out of disable, kicks off the config serializer, unmutes once audio is
// locked, and on a qualified fault walks mute -> disable -> backoff -> retry. Too many
// faults latch a lockout that only clear_in (or reset) releases.

module amp_fault_supervisor #(
    parameter int unsigned EN_WAIT_CYCLES = 1000,
    parameter int unsigned CFG_TIMEOUT    = 5000,
    parameter int unsigned BACKOFF_CYCLES = 20000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned FAULT_FILTER   = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       audio_locked_in,
    input  logic       nerror_in,
    input  logic       cfg_done_in,
    input  logic       clear_in,
    output logic       nenable_out,
    output logic       nmute_out,
    output logic       cfg_start_out,
    output logic [3:0] fault_count_out,
    output logic       lockout_out,
    output logic [2:0] state_out
);

    localparam int unsigned TMAX_A = (EN_WAIT_CYCLES > CFG_TIMEOUT) ? EN_WAIT_CYCLES : CFG_TIMEOUT;
    localparam int unsigned TMAX   = (TMAX_A > BACKOFF_CYCLES) ? TMAX_A : BACKOFF_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam int FW = $clog2(FAULT_FILTER + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EN_WAIT = 3'd1,
        CONFIG  = 3'd2,
        RUN     = 3'd3,
        FAULT   = 3'd4,
        BACKOFF = 3'd5,
        LOCKOUT = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    fault_count_q, fault_count_d;
    logic          nenable_q, nenable_d;
    logic          nmute_q, nmute_d;
    logic          cfg_start_q, cfg_start_d;
    logic          lockout_q, lockout_d;

    logic          nerror_s1_q, nerror_s2_q;
    logic [FW-1:0] filter_q;
    logic          fault_det;

    // Bring the asynchronous fault pin into the clock domain; idle level is high (no fault).
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            nerror_s1_q <= 1'b1;
            nerror_s2_q <= 1'b1;
        end else begin
            nerror_s1_q <= nerror_in;
            nerror_s2_q <= nerror_s1_q;
        end
    end

    // Count consecutive low synced samples, saturating at the filter length; any high sample restarts.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            filter_q <= '0;
        end else if (nerror_s2_q) begin
            filter_q <= '0;
        end else if (filter_q != FW'(FAULT_FILTER)) begin
            filter_q <= filter_q + FW'(1);
        end
    end

    assign fault_det = (filter_q == FW'(FAULT_FILTER));

    // Next-state, timer and fault-count logic; registered outputs are derived from the next state.
    always_comb begin
        state_d       = state_q;
        timer_d       = '0;
        fault_count_d = fault_count_q;

        case (state_q)
            IDLE: begin
                state_d = EN_WAIT;
                timer_d = TW'(EN_WAIT_CYCLES);
            end
            EN_WAIT: begin
                if (fault_det) begin
                    state_d = FAULT;
                end else if (timer_q == TW'(1)) begin
                    state_d = CONFIG;
                    timer_d = TW'(CFG_TIMEOUT);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            CONFIG: begin
                if (fault_det) begin
                    state_d = FAULT;
                end else if (cfg_done_in) begin
                    state_d = RUN;
                end else if (timer_q == TW'(1)) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RUN: begin
                if (fault_det) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (fault_count_q >= 4'(MAX_RETRIES)) begin
                    state_d = LOCKOUT;
                end else begin
                    state_d = BACKOFF;
                    timer_d = TW'(BACKOFF_CYCLES);
                end
            end
            BACKOFF: begin
                if (timer_q == TW'(1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOCKOUT: begin
                if (clear_in) begin
                    state_d       = IDLE;
                    fault_count_d = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // FAULT never persists, so landing in it always means a fresh fault entry.
        if (state_d == FAULT) begin
            fault_count_d = (fault_count_q == 4'hF) ? 4'hF : fault_count_q + 4'd1;
        end

        nenable_d   = !((state_d == EN_WAIT) || (state_d == CONFIG) ||
                        (state_d == RUN)     || (state_d == FAULT));
        nmute_d     = (state_q == RUN) && (state_d == RUN) && audio_locked_in;
        cfg_start_d = (state_q == EN_WAIT) && (state_d == CONFIG);
        lockout_d   = (state_d == LOCKOUT);
    end

    // State register and all outputs share one edge; reset disables the amp immediately.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            fault_count_q <= 4'd0;
            nenable_q     <= 1'b1;
            nmute_q       <= 1'b0;
            cfg_start_q   <= 1'b0;
            lockout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            fault_count_q <= fault_count_d;
            nenable_q     <= nenable_d;
            nmute_q       <= nmute_d;
            cfg_start_q   <= cfg_start_d;
            lockout_q     <= lockout_d;
        end
    end

    assign nenable_out     = nenable_q;
    assign nmute_out       = nmute_q;
    assign cfg_start_out   = cfg_start_q;
    assign fault_count_out = fault_count_q;
    assign lockout_out     = lockout_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_amp_fault_supervisor.sv
// tb_amp_fault_supervisor
// Directed bench for the amp supervisor with short timing parameters so every sequence
// (power-up, glitch rejection, fault recovery, timeouts, lockout, races, reset) fits in a
// few hundred cycles. Expected timings are worked out by hand from the parameters below.

module tb_amp_fault_supervisor;

    localparam int EW = 8;
    localparam int CT = 16;
    localparam int BO = 32;
    localparam int MR = 3;
    localparam int FF = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EN_WAIT = 3'd1;
    localparam logic [2:0] S_CONFIG  = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;
    localparam logic [2:0] S_BACKOFF = 3'd5;
    localparam logic [2:0] S_LOCKOUT = 3'd6;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       audio_locked_in;
    logic       nerror_in;
    logic       cfg_done_in;
    logic       clear_in;
    logic       nenable_out;
    logic       nmute_out;
    logic       cfg_start_out;
    logic [3:0] fault_count_out;
    logic       lockout_out;
    logic [2:0] state_out;

    int passCount  = 0;
    int checkCount = 0;
    int n;

    amp_fault_supervisor #(
        .EN_WAIT_CYCLES(EW),
        .CFG_TIMEOUT   (CT),
        .BACKOFF_CYCLES(BO),
        .MAX_RETRIES   (MR),
        .FAULT_FILTER  (FF)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .audio_locked_in(audio_locked_in),
        .nerror_in      (nerror_in),
        .cfg_done_in    (cfg_done_in),
        .clear_in       (clear_in),
        .nenable_out    (nenable_out),
        .nmute_out      (nmute_out),
        .cfg_start_out  (cfg_start_out),
        .fault_count_out(fault_count_out),
        .lockout_out    (lockout_out),
        .state_out      (state_out)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk_in = ~clk_in;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Set all synchronous inputs at once; they are sampled on the next rising edge.
    task automatic applyStimulus(input logic lock, input logic nerr, input logic done, input logic clr);
        audio_locked_in = lock;
        nerror_in       = nerr;
        cfg_done_in     = done;
        clear_in        = clr;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Advance until the state matches, giving up after a budget; n is the number of edges taken.
    task automatic waitState(input string tag, input logic [2:0] target, input int budget, output int cycles);
        cycles = 0;
        while (state_out !== target && cycles < budget) begin
            tick();
            cycles++;
        end
        checkOutput(tag, 32'(state_out), 32'(target));
    endtask

    initial begin
        reset_in = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("reset state", 32'(state_out), 32'(S_IDLE));
        checkOutput("reset nenable", 32'(nenable_out), 1);
        checkOutput("reset nmute", 32'(nmute_out), 0);
        checkOutput("reset cfg_start", 32'(cfg_start_out), 0);
        checkOutput("reset count", 32'(fault_count_out), 0);
        checkOutput("reset lockout", 32'(lockout_out), 0);

        $display("[TB] power-up");
        reset_in = 1'b0;
        tick();
        checkOutput("pu en_wait", 32'(state_out), 32'(S_EN_WAIT));
        checkOutput("pu nenable", 32'(nenable_out), 0);
        waitState("pu config", S_CONFIG, 40, n);
        checkOutput("pu en_wait length", 32'(n), 32'(EW));
        checkOutput("pu cfg_start", 32'(cfg_start_out), 1);
        tick();
        checkOutput("pu cfg_start pulse", 32'(cfg_start_out), 0);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("pu run", 32'(state_out), 32'(S_RUN));
        checkOutput("pu run nmute lag", 32'(nmute_out), 0);
        tick();
        checkOutput("pu nmute", 32'(nmute_out), 1);

        $display("[TB] glitch rejection");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("glitch nmute/state", 32'({nmute_out, state_out}), 32'({1'b1, S_RUN}));
        end
        checkOutput("glitch count", 32'(fault_count_out), 0);

        $display("[TB] fault in RUN");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("run fault k+5 state", 32'(state_out), 32'(S_RUN));
        checkOutput("run fault k+5 nmute", 32'(nmute_out), 1);
        tick();
        checkOutput("run fault k+6 state", 32'(state_out), 32'(S_FAULT));
        checkOutput("run fault nmute", 32'(nmute_out), 0);
        checkOutput("run fault nenable", 32'(nenable_out), 0);
        checkOutput("run fault count", 32'(fault_count_out), 1);
        tick();
        checkOutput("run fault backoff", 32'(state_out), 32'(S_BACKOFF));
        checkOutput("run fault disable", 32'(nenable_out), 1);
        repeat (2) tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        waitState("backoff done", S_IDLE, 60, n);
        checkOutput("backoff length", 32'(n + 2), 32'(BO));
        tick();
        checkOutput("retry en_wait", 32'(state_out), 32'(S_EN_WAIT));
        checkOutput("retry nenable", 32'(nenable_out), 0);
        checkOutput("retry count", 32'(fault_count_out), 1);

        $display("[TB] fault vs cfg_done race");
        waitState("race config", S_CONFIG, 40, n);
        checkOutput("race en_wait length", 32'(n), 32'(EW));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("race pre state", 32'(state_out), 32'(S_CONFIG));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("race fault wins", 32'(state_out), 32'(S_FAULT));
        checkOutput("race count", 32'(fault_count_out), 2);

        $display("[TB] persistent fault re-faults through EN_WAIT");
        tick();
        checkOutput("persist backoff", 32'(state_out), 32'(S_BACKOFF));
        waitState("persist idle", S_IDLE, 60, n);
        checkOutput("persist backoff length", 32'(n), 32'(BO));
        tick();
        checkOutput("persist en_wait", 32'(state_out), 32'(S_EN_WAIT));
        tick();
        checkOutput("persist refault", 32'(state_out), 32'(S_FAULT));
        checkOutput("persist count", 32'(fault_count_out), 3);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("persist lockout", 32'(state_out), 32'(S_LOCKOUT));
        checkOutput("persist lockout flag", 32'(lockout_out), 1);

        $display("[TB] lockout hold and clear");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("lockout ignores cfg_done", 32'(state_out), 32'(S_LOCKOUT));
        checkOutput("lockout nenable", 32'(nenable_out), 1);
        checkOutput("lockout nmute", 32'(nmute_out), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clear idle", 32'(state_out), 32'(S_IDLE));
        checkOutput("clear count", 32'(fault_count_out), 0);
        checkOutput("clear lockout", 32'(lockout_out), 0);

        $display("[TB] config timeouts");
        for (int i = 1; i <= MR; i++) begin
            waitState("timeout config", S_CONFIG, 100, n);
            waitState("timeout fault", S_FAULT, 40, n);
            checkOutput("timeout length", 32'(n), 32'(CT));
            checkOutput("timeout count", 32'(fault_count_out), 32'(i));
            tick();
            checkOutput("timeout next", 32'(state_out), (i < MR) ? 32'(S_BACKOFF) : 32'(S_LOCKOUT));
        end
        checkOutput("timeout lockout flag", 32'(lockout_out), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clear2 idle", 32'(state_out), 32'(S_IDLE));

        $display("[TB] repeat power-up and lock drop");
        tick();
        checkOutput("pu2 nenable", 32'(nenable_out), 0);
        waitState("pu2 config", S_CONFIG, 40, n);
        checkOutput("pu2 en_wait length", 32'(n), 32'(EW));
        checkOutput("pu2 cfg_start", 32'(cfg_start_out), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("pu2 nmute", 32'(nmute_out), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("lock drop nmute", 32'(nmute_out), 0);
        checkOutput("lock drop state", 32'(state_out), 32'(S_RUN));
        tick();
        checkOutput("lock drop count", 32'(fault_count_out), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("lock restore nmute", 32'(nmute_out), 1);

        $display("[TB] reset mid-BACKOFF");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitState("rst backoff", S_BACKOFF, 20, n);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        checkOutput("rst pre nenable", 32'(nenable_out), 1);
        checkOutput("rst pre count", 32'(fault_count_out), 1);
        #3;
        reset_in = 1'b1;
        #1;
        checkOutput("rst async state", 32'(state_out), 32'(S_IDLE));
        checkOutput("rst async nenable", 32'(nenable_out), 1);
        checkOutput("rst async count", 32'(fault_count_out), 0);
        checkOutput("rst async nmute", 32'(nmute_out), 0);
        tick();
        reset_in = 1'b0;
        tick();
        checkOutput("rst restart", 32'(state_out), 32'(S_EN_WAIT));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
